// File: rtl/aemb_wb_arb_pkg.sv
// Shared definitions for the aeMB two-to-one Wishbone arbiter.
package aemb_wb_arb_pkg;

    // Arbiter states. The encoding is fixed so that waveforms and
    // debug probes read the same in every build.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Instruction fetches are always full-word reads.
    localparam logic [3:0] FETCH_SEL = 4'hF;

    // Default width of the optional timeout counter.
    localparam int DEFAULT_TW = 4;

endpackage : aemb_wb_arb_pkg

// File: rtl/aemb_wb_arb.sv
// aeMB instruction/data bus arbiter: shares one classic-cycle Wishbone
// port (xwb) between the core's fetch bus (iwb) and data bus (dwb).
// One transfer at a time. Grant and command outputs are registered.
// Simultaneous requests are resolved round-robin.
// Optional feature: define AEMB_ARB_TIMEOUT_EN to terminate a grant that
// waits 2^TW-1 cycles without an acknowledge. The terminated transfer
// returns zero data and raises arb_tmo_o for one cycle.
module aemb_wb_arb
    import aemb_wb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int TW = DEFAULT_TW
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,

    input  logic          iwb_stb_i,
    input  logic [AW-1:2] iwb_adr_i,
    output logic          iwb_ack_o,
    output logic [31:0]   iwb_dat_o,

    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic          dwb_ack_o,
    output logic [31:0]   dwb_dat_o,

    output logic          xwb_stb_o,
    output logic          xwb_wre_o,
    output logic [3:0]    xwb_sel_o,
    output logic [AW-1:2] xwb_adr_o,
    output logic [31:0]   xwb_dat_o,
    input  logic [31:0]   xwb_dat_i,
    input  logic          xwb_ack_i,

    output logic          arb_tmo_o
);

    arb_state_e state;
    arb_state_e state_nxt;

    logic last_d;    // 1: the most recent grant went to the data bus
    logic grant_i;   // entering GNT_I at the coming edge
    logic grant_d;   // entering GNT_D at the coming edge
    logic done;      // the current grant ends at the coming edge
    logic tmo_fire;  // the timeout completes the current grant this cycle

    // Next-state decode: round-robin on a tie, leave a grant on ack or timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so that
        // no path through the case statement can leave a latch behind.
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // A lone request wins. On a tie, I wins only if D was last served.
                if (iwb_stb_i && (!dwb_stb_i || last_d)) begin
                    state_nxt = GNT_I;
                    grant_i   = 1'b1;
                end else if (dwb_stb_i) begin
                    state_nxt = GNT_D;
                    grant_d   = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (xwb_ack_i || tmo_fire) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk_i) begin
        // NOTE: sequential state is written only with non-blocking
        // assignments, so every register samples pre-edge values.
        if (sys_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command register: loaded on a grant, held for the whole transfer.
    always_ff @(posedge sys_clk_i) begin
        // NOTE: these are single control registers with defined reset
        // values, so they are reset. A wide storage array would be left
        // unreset instead.
        if (sys_rst_i) begin
            xwb_stb_o <= 1'b0;
            xwb_wre_o <= 1'b0;
            xwb_sel_o <= 4'h0;
            xwb_adr_o <= '0;
            xwb_dat_o <= 32'h0;
            last_d    <= 1'b0;
        end else if (grant_i) begin
            xwb_stb_o <= 1'b1;
            xwb_wre_o <= 1'b0;
            xwb_sel_o <= FETCH_SEL;
            xwb_adr_o <= iwb_adr_i;
            xwb_dat_o <= 32'h0;
            last_d    <= 1'b0;
        end else if (grant_d) begin
            xwb_stb_o <= 1'b1;
            xwb_wre_o <= dwb_wre_i;
            xwb_sel_o <= dwb_sel_i;
            xwb_adr_o <= dwb_adr_i;
            xwb_dat_o <= dwb_dat_i;
            last_d    <= 1'b1;
        end else if (done) begin
            // The address and data stay put. Only the strobe drops.
            xwb_stb_o <= 1'b0;
        end
    end

    // Acks are combinational. An ack seen in IDLE reaches neither requester.
    assign iwb_ack_o = (state == GNT_I) && (xwb_ack_i || tmo_fire);
    assign dwb_ack_o = (state == GNT_D) && (xwb_ack_i || tmo_fire);

    // Read data passes straight through, except on a timed-out completion.
    assign iwb_dat_o = tmo_fire ? 32'h0 : xwb_dat_i;
    assign dwb_dat_o = tmo_fire ? 32'h0 : xwb_dat_i;

`ifdef AEMB_ARB_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;

    // Timeout counter: zero in the first grant cycle, counts unacked grant cycles.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tmo_cnt <= '0;
        end else if (grant_i || grant_d) begin
            tmo_cnt <= '0;
        end else if ((state != IDLE) && !xwb_ack_i) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A real ack in the same cycle takes precedence over the timeout.
    assign tmo_fire  = (state != IDLE) && !xwb_ack_i && (&tmo_cnt);
    assign arb_tmo_o = tmo_fire;
`else
    assign tmo_fire  = 1'b0;
    assign arb_tmo_o = 1'b0;
`endif

endmodule : aemb_wb_arb

// File: tb/tb_aemb_wb_arb.sv
// Self-checking bench for aemb_wb_arb: a vector table, hand-written corner
// sequences, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_aemb_wb_arb;

    localparam int AW = 32;
    localparam int TW = 4;

    logic          sys_clk_i = 1'b0;
    logic          sys_rst_i;
    logic          iwb_stb_i;
    logic [AW-1:2] iwb_adr_i;
    logic          iwb_ack_o;
    logic [31:0]   iwb_dat_o;
    logic          dwb_stb_i;
    logic          dwb_wre_i;
    logic [3:0]    dwb_sel_i;
    logic [AW-1:2] dwb_adr_i;
    logic [31:0]   dwb_dat_i;
    logic          dwb_ack_o;
    logic [31:0]   dwb_dat_o;
    logic          xwb_stb_o;
    logic          xwb_wre_o;
    logic [3:0]    xwb_sel_o;
    logic [AW-1:2] xwb_adr_o;
    logic [31:0]   xwb_dat_o;
    logic [31:0]   xwb_dat_i;
    logic          xwb_ack_i;
    logic          arb_tmo_o;

    int errors = 0;
    int checks = 0;

    aemb_wb_arb #(.AW(AW), .TW(TW)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .iwb_stb_i (iwb_stb_i),
        .iwb_adr_i (iwb_adr_i),
        .iwb_ack_o (iwb_ack_o),
        .iwb_dat_o (iwb_dat_o),
        .dwb_stb_i (dwb_stb_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_adr_i (dwb_adr_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_ack_o (dwb_ack_o),
        .dwb_dat_o (dwb_dat_o),
        .xwb_stb_o (xwb_stb_o),
        .xwb_wre_o (xwb_wre_o),
        .xwb_sel_o (xwb_sel_o),
        .xwb_adr_o (xwb_adr_o),
        .xwb_dat_o (xwb_dat_o),
        .xwb_dat_i (xwb_dat_i),
        .xwb_ack_i (xwb_ack_i),
        .arb_tmo_o (arb_tmo_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        iwb_stb_i = 1'b0;
        iwb_adr_i = '0;
        dwb_stb_i = 1'b0;
        dwb_wre_i = 1'b0;
        dwb_sel_i = 4'h0;
        dwb_adr_i = '0;
        dwb_dat_i = 32'h0;
        xwb_ack_i = 1'b0;
        xwb_dat_i = 32'h0;
    endtask

    // One reset edge with idle inputs. Returns just after a negedge, reset low.
    task automatic reset_dut();
        @(negedge sys_clk_i);
        sys_rst_i = 1'b1;
        idle_inputs();
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
    endtask

    // Each cycle: set inputs just after negedge, then sample at +1ns.
    typedef struct {
        logic        istb;
        logic        dstb;
        logic        ack;
        logic [31:0] rdat;
        logic        e_stb;
        logic        e_iack;
        logic        e_dack;
        logic [29:0] e_adr;
    } vec_t;

    vec_t vecs[9];

    // Random-run model state (transaction level).
    int          owner;       // 0 none, 1 fetch bus, 2 data bus
    bit          last_was_d;
    bit          pend_i, pend_d;
    logic [29:0] a_i, a_d;
    logic        w_d;
    logic [3:0]  s_d;
    logic [31:0] dd_d;
    int          waited;
    logic        ack;

    initial begin
        sys_rst_i = 1'b1;
        idle_inputs();

        // ---------------- reset state ----------------
        reset_dut();
        #1;
        check("rst_stb",  xwb_stb_o, 1'b0);
        check("rst_wre",  xwb_wre_o, 1'b0);
        check("rst_sel",  xwb_sel_o, 4'h0);
        check("rst_adr",  xwb_adr_o, 30'h0);
        check("rst_dat",  xwb_dat_o, 32'h0);
        check("rst_iack", iwb_ack_o, 1'b0);
        check("rst_dack", dwb_ack_o, 1'b0);
        check("rst_tmo",  arb_tmo_o, 1'b0);

        // ---------------- vector table ----------------
        //           istb  dstb  ack   rdat           stb   iack  dack  adr
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 30'h000}; // stray ack in IDLE
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 30'h000}; // fetch sampled
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'hB8000010, 1'b1, 1'b1, 1'b0, 30'h100}; // zero-wait ack
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 30'h100}; // IDLE gap
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 30'h100}; // tie, I was last
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 30'h200}; // D granted, wait
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 30'h200}; // D ack
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 30'h200}; // IDLE gap
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0, 30'h100}; // I served
        iwb_adr_i = 30'h100;
        dwb_adr_i = 30'h200;
        dwb_sel_i = 4'h5;
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk_i);
            iwb_stb_i = vecs[i].istb;
            dwb_stb_i = vecs[i].dstb;
            xwb_ack_i = vecs[i].ack;
            xwb_dat_i = vecs[i].rdat;
            #1;
            check($sformatf("vec%0d_stb", i),  xwb_stb_o, vecs[i].e_stb);
            check($sformatf("vec%0d_iack", i), iwb_ack_o, vecs[i].e_iack);
            check($sformatf("vec%0d_dack", i), dwb_ack_o, vecs[i].e_dack);
            check($sformatf("vec%0d_adr", i),  xwb_adr_o, vecs[i].e_adr);
            check($sformatf("vec%0d_idat", i), iwb_dat_o, vecs[i].rdat);
            check($sformatf("vec%0d_ddat", i), dwb_dat_o, vecs[i].rdat);
            if (vecs[i].e_iack) begin
                check($sformatf("vec%0d_isel", i), xwb_sel_o, 4'hF);
                check($sformatf("vec%0d_iwre", i), xwb_wre_o, 1'b0);
            end
        end

        // ---------------- first ties after reset: D then I ----------------
        reset_dut();
        iwb_adr_i = 30'h0AA;
        dwb_adr_i = 30'h0BB;
        @(negedge sys_clk_i);
        iwb_stb_i = 1'b1;
        dwb_stb_i = 1'b1;
        #1;
        check("tie_idle_stb", xwb_stb_o, 1'b0);
        @(negedge sys_clk_i);
        xwb_ack_i = 1'b1;
        #1;
        check("tie1_dack", dwb_ack_o, 1'b1);
        check("tie1_iack", iwb_ack_o, 1'b0);
        check("tie1_adr",  xwb_adr_o, 30'h0BB);
        @(negedge sys_clk_i);
        xwb_ack_i = 1'b0;              // D keeps requesting: second tie next edge
        #1;
        check("tie_gap_stb", xwb_stb_o, 1'b0);
        @(negedge sys_clk_i);
        xwb_ack_i = 1'b1;
        #1;
        check("tie2_iack", iwb_ack_o, 1'b1);
        check("tie2_dack", dwb_ack_o, 1'b0);
        check("tie2_adr",  xwb_adr_o, 30'h0AA);

        // ---------------- write with 3 wait states ----------------
        reset_dut();
        @(negedge sys_clk_i);
        dwb_stb_i = 1'b1;
        dwb_wre_i = 1'b1;
        dwb_sel_i = 4'b0011;
        dwb_adr_i = 30'h3C;
        dwb_dat_i = 32'h0000ABCD;
        #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge sys_clk_i);
            xwb_ack_i = (c == 4);
            #1;
            check($sformatf("wr_c%0d_stb", c),  xwb_stb_o, 1'b1);
            check($sformatf("wr_c%0d_wre", c),  xwb_wre_o, 1'b1);
            check($sformatf("wr_c%0d_sel", c),  xwb_sel_o, 4'b0011);
            check($sformatf("wr_c%0d_adr", c),  xwb_adr_o, 30'h3C);
            check($sformatf("wr_c%0d_dat", c),  xwb_dat_o, 32'h0000ABCD);
            check($sformatf("wr_c%0d_dack", c), dwb_ack_o, (c == 4));
        end
        @(negedge sys_clk_i);
        dwb_stb_i = 1'b0;
        xwb_ack_i = 1'b0;
        #1;
        check("wr_after_stb", xwb_stb_o, 1'b0);

        // ---------------- reset during GNT_D ----------------
        reset_dut();
        @(negedge sys_clk_i);
        dwb_stb_i = 1'b1;
        dwb_adr_i = 30'h77;
        #1;
        @(negedge sys_clk_i);
        #1;
        check("mid_granted_stb", xwb_stb_o, 1'b1);
        sys_rst_i = 1'b1;
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        dwb_stb_i = 1'b0;
        xwb_ack_i = 1'b1;              // stray ack after the abort
        #1;
        check("mid_rst_stb",  xwb_stb_o, 1'b0);
        check("mid_rst_dack", dwb_ack_o, 1'b0);
        check("mid_rst_iack", iwb_ack_o, 1'b0);
        @(negedge sys_clk_i);
        xwb_ack_i = 1'b0;
        #1;
        check("mid_rst_idle", xwb_stb_o, 1'b0);

`ifdef AEMB_ARB_TIMEOUT_EN
        // ---------------- timeout, slave never acks ----------------
        begin
            int          hit;
            logic        tmo_seen;
            logic [31:0] dat_seen;
            hit      = 0;
            tmo_seen = 1'b0;
            dat_seen = 32'hFFFFFFFF;
            reset_dut();
            @(negedge sys_clk_i);
            dwb_stb_i = 1'b1;
            dwb_adr_i = 30'h44;
            xwb_dat_i = 32'hDEADBEEF;
            #1;
            // k=1 is the first cycle after the grant edge (counter 0), so the
            // counter reads 15 at k=16: the cycle following edge grant+15.
            for (int k = 1; k <= 24 && hit == 0; k++) begin
                @(negedge sys_clk_i);
                #1;
                if (dwb_ack_o || arb_tmo_o) begin
                    hit      = k;
                    tmo_seen = arb_tmo_o;
                    dat_seen = dwb_dat_o;
                end
            end
            check("tmo_cycle", hit, 16);
            check("tmo_pulse", tmo_seen, 1'b1);
            check("tmo_data",  dat_seen, 32'h0);
            @(negedge sys_clk_i);
            dwb_stb_i = 1'b0;
            #1;
            check("tmo_one_cycle", arb_tmo_o, 1'b0);
            check("tmo_idle_stb",  xwb_stb_o, 1'b0);
            @(negedge sys_clk_i);
            iwb_stb_i = 1'b1;
            iwb_adr_i = 30'h55;
            #1;
            @(negedge sys_clk_i);
            xwb_ack_i = 1'b1;
            xwb_dat_i = 32'h600DF00D;
            #1;
            check("tmo_next_iack", iwb_ack_o, 1'b1);
            check("tmo_next_data", iwb_dat_o, 32'h600DF00D);
            check("tmo_next_tmo",  arb_tmo_o, 1'b0);
            @(negedge sys_clk_i);
            idle_inputs();
        end
`endif

        // ---------------- back-to-back, both always requesting ----------------
        begin
            int n;
            bit expect_d;
            n        = 0;
            expect_d = 1'b1;           // first tie after reset goes to D
            reset_dut();
            iwb_stb_i = 1'b1;
            iwb_adr_i = 30'h1;
            dwb_stb_i = 1'b1;
            dwb_adr_i = 30'h2;
            for (int c = 0; c < 120 && n < 20; c++) begin
                @(negedge sys_clk_i);
                xwb_ack_i = xwb_stb_o;     // zero-wait slave
                xwb_dat_i = $urandom;
                #1;
                check("b2b_no_dual_ack", iwb_ack_o & dwb_ack_o, 1'b0);
                if (iwb_ack_o || dwb_ack_o) begin
                    check($sformatf("b2b_alt%0d", n), dwb_ack_o, expect_d);
                    expect_d = !expect_d;
                    n++;
                end
            end
            check("b2b_count", n, 20);
        end

        // ---------------- randomized run against the model ----------------
        reset_dut();
        owner      = 0;
        last_was_d = 1'b0;
        pend_i     = 1'b0;
        pend_d     = 1'b0;
        waited     = 0;
        a_i = '0; a_d = '0; w_d = 1'b0; s_d = 4'h0; dd_d = 32'h0;
        for (int c = 0; c < 400; c++) begin
            @(negedge sys_clk_i);
            if (!pend_i && $urandom_range(1, 0) == 1) begin
                pend_i = 1'b1;
                a_i    = 30'($urandom);
            end
            if (!pend_d && $urandom_range(1, 0) == 1) begin
                pend_d = 1'b1;
                a_d    = 30'($urandom);
                w_d    = 1'($urandom);
                s_d    = 4'($urandom);
                dd_d   = $urandom;
            end
            iwb_stb_i = pend_i;
            iwb_adr_i = a_i;
            dwb_stb_i = pend_d;
            dwb_adr_i = a_d;
            dwb_wre_i = w_d;
            dwb_sel_i = s_d;
            dwb_dat_i = dd_d;
            ack = ((owner != 0) && (waited >= 6)) ? 1'b1 : ($urandom_range(2, 0) == 0);
            xwb_ack_i = ack;
            xwb_dat_i = $urandom;
            #1;
            check("rnd_stb",  xwb_stb_o, (owner != 0));
            check("rnd_iack", iwb_ack_o, (owner == 1) && ack);
            check("rnd_dack", dwb_ack_o, (owner == 2) && ack);
            check("rnd_tmo",  arb_tmo_o, 1'b0);
            if (owner == 1) begin
                check("rnd_i_adr", xwb_adr_o, a_i);
                check("rnd_i_sel", xwb_sel_o, 4'hF);
                check("rnd_i_wre", xwb_wre_o, 1'b0);
                if (ack) check("rnd_i_dat", iwb_dat_o, xwb_dat_i);
            end else if (owner == 2) begin
                check("rnd_d_adr", xwb_adr_o, a_d);
                check("rnd_d_sel", xwb_sel_o, s_d);
                check("rnd_d_wre", xwb_wre_o, w_d);
                check("rnd_d_wdat", xwb_dat_o, dd_d);
                if (ack) check("rnd_d_dat", dwb_dat_o, xwb_dat_i);
            end
            // Advance the model: a transfer ends on ack; a free bus with
            // pending requests goes to the one not served last on a tie.
            if (owner != 0) begin
                if (ack) begin
                    if (owner == 1) pend_i = 1'b0;
                    else            pend_d = 1'b0;
                    owner  = 0;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else if (pend_i || pend_d) begin
                if (pend_i && pend_d) owner = last_was_d ? 1 : 2;
                else                  owner = pend_i ? 1 : 2;
                last_was_d = (owner == 2);
                waited     = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_aemb_wb_arb
